// File: rtl/char_uart_tx.sv
// Serial 8N1 transmitter for the dataMem character buffer.
// Snapshots the buffer on start and sends it index 0 first, optionally stopping at NUL.
module char_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned N_CHARS      = 64,
    parameter bit          STOP_AT_NUL  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [8*N_CHARS-1:0]       charArray,
    output logic                       tx,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_CHARS)-1:0] cur_idx
);

    localparam int unsigned IdxW = $clog2(N_CHARS);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop
    } state_t;

    state_t          state;
    logic [CntW-1:0] baud;
    logic [2:0]      bitn;
    logic [7:0]      shreg;
    logic [7:0]      snap [N_CHARS];
    logic [7:0]      cur_char;
    logic            baud_end;

    assign cur_char = snap[cur_idx];
    assign baud_end = (baud == CntW'(CLKS_PER_BIT - 1));

    // Pure data path: captured only when a start is accepted, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == StIdle && start) begin
            for (int i = 0; i < int'(N_CHARS); i++) begin
                snap[i] <= charArray[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= StIdle;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            cur_idx <= '0;
            baud    <= '0;
            bitn    <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            baud <= baud + 1'b1;
            unique case (state)
                StIdle: begin
                    baud <= '0;
                    tx   <= 1'b1;
                    if (start) begin
                        state   <= StLoad;
                        busy    <= 1'b1;
                        cur_idx <= '0;
                    end
                end
                StLoad: begin
                    baud <= '0;
                    if (STOP_AT_NUL && cur_char == 8'h00) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        shreg <= cur_char;
                        state <= StStart;
                        tx    <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_end) begin
                        baud  <= '0;
                        bitn  <= '0;
                        state <= StData;
                        tx    <= shreg[0];
                    end
                end
                StData: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bitn == 3'd7) begin
                            state <= StStop;
                            tx    <= 1'b1;
                        end else begin
                            bitn  <= bitn + 3'd1;
                            shreg <= shreg >> 1;
                            tx    <= shreg[1];
                        end
                    end
                end
                StStop: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (cur_idx == IdxW'(N_CHARS - 1)) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cur_idx <= cur_idx + 1'b1;
                            state   <= StLoad;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
